// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order core's completion-side blocks.
package ooo_pkg;

  localparam int unsigned DEF_TAG_W = 32;
  localparam int unsigned DEF_VAL_W = 32;

  // Tag 0 means "no instruction" in the ROB.
  localparam int unsigned NULL_TAG  = 0;

  // Bits needed to hold values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/rob_finish_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible entry at or after ptr.
module rr_pick
  import ooo_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        eligible,
  input  logic [clog2(N)-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [clog2(N)-1:0] grant_idx,
  output logic                grant_any
);

  localparam int unsigned IDX_W = clog2(N);

  logic [IDX_W:0] pos;

  // Walk ptr, ptr+1, ... modulo N and take the first eligible entry.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
      if (!grant_any && eligible[pos[IDX_W-1:0]]) begin
        grant[pos[IDX_W-1:0]] = 1'b1;
        grant_idx             = pos[IDX_W-1:0];
        grant_any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_finish_arbiter.sv
// Shares the ROB completion port among NUM_REQ execution units.
module rob_finish_arbiter
  import ooo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = DEF_TAG_W,
  parameter int unsigned VAL_W   = DEF_VAL_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         hold,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
  input  logic [NUM_REQ*VAL_W-1:0]     req_val,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         finish_instr,
  output logic [TAG_W-1:0]             instr_to_finish,
  output logic [VAL_W-1:0]             finish_val,
  output logic [clog2(NUM_REQ+1)-1:0]  pending
);

  localparam int unsigned PTR_W = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(NUM_REQ+1);

  logic [NUM_REQ-1:0] full;
  logic [TAG_W-1:0]   slot_tag [NUM_REQ];
  logic [VAL_W-1:0]   slot_val [NUM_REQ];
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   next_ptr;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] take;

  assign eligible = full & {NUM_REQ{~hold & ~flush}};

  rr_pick #(.N(NUM_REQ)) u_pick (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A slot accepts when empty or draining this cycle; nothing during reset/flush.
  always_comb begin
    req_ready = (reset && !flush) ? (~full | grant) : '0;
    take      = req_valid & req_ready;
    next_ptr  = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  // Occupancy count of the registered full bits.
  always_comb begin
    pending = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) pending = pending + CNT_W'(full[k]);
  end

  // Slot payload capture; only meaningful while the matching full bit is set.
  always_ff @(posedge clock) begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (take[k]) begin
        slot_tag[k] <= req_tag[k*TAG_W +: TAG_W];
        slot_val[k] <= req_val[k*VAL_W +: VAL_W];
      end
    end
  end

  // Full bits, round-robin pointer and registered completion strobe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      full            <= '0;
      ptr             <= '0;
      finish_instr    <= 1'b0;
      instr_to_finish <= '0;
      finish_val      <= '0;
    end else if (flush) begin
      full            <= '0;
      finish_instr    <= 1'b0;
      instr_to_finish <= '0;
      finish_val      <= '0;
    end else begin
      finish_instr    <= grant_any;
      instr_to_finish <= grant_any ? slot_tag[grant_idx] : '0;
      finish_val      <= grant_any ? slot_val[grant_idx] : '0;
      if (grant_any) ptr <= next_ptr;
      // Refill wins over drain; a null tag leaves the slot empty.
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (take[k])       full[k] <= (req_tag[k*TAG_W +: TAG_W] != TAG_W'(NULL_TAG));
        else if (grant[k]) full[k] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rob_finish_arbiter.sv
// Self-checking bench for rob_finish_arbiter: directed scenarios plus random traffic.
module tb_rob_finish_arbiter;

  localparam int NR = 4;
  localparam int TW = 32;
  localparam int VW = 32;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              hold;
  logic [NR-1:0]     req_valid;
  logic [NR*TW-1:0]  req_tag;
  logic [NR*VW-1:0]  req_val;
  logic [NR-1:0]     req_ready;
  logic              finish_instr;
  logic [TW-1:0]     instr_to_finish;
  logic [VW-1:0]     finish_val;
  logic [2:0]        pending;

  int checks;
  int failures;

  rob_finish_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .VAL_W(VW)) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .hold            (hold),
    .req_valid       (req_valid),
    .req_tag         (req_tag),
    .req_val         (req_val),
    .req_ready       (req_ready),
    .finish_instr    (finish_instr),
    .instr_to_finish (instr_to_finish),
    .finish_val      (finish_val),
    .pending         (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_live;
  bit          m_full [NR];
  logic [31:0] m_tag  [NR];
  logic [31:0] m_val  [NR];
  int          m_ptr;
  bit          m_fin;
  logic [31:0] m_ftag;
  logic [31:0] m_fval;
  int          mg;
  logic [NR-1:0] mrdy;
  int          mcnt;

  function automatic int model_grant();
    int g;
    g = -1;
    if (reset && !hold && !flush) begin
      for (int i = 0; i < NR; i++) begin
        int k;
        k = (m_ptr + i) % NR;
        if (g < 0 && m_full[k]) g = k;
      end
    end
    return g;
  endfunction

  function automatic logic [NR-1:0] model_ready(input int g);
    logic [NR-1:0] r;
    for (int k = 0; k < NR; k++) r[k] = reset && !flush && (!m_full[k] || g == k);
    return r;
  endfunction

  // Compare on the falling edge, advance the model on the rising edge.
  always begin
    @(negedge clock);
    if (m_live) begin
      mg   = model_grant();
      mrdy = model_ready(mg);
      mcnt = 0;
      for (int k = 0; k < NR; k++) mcnt += int'(m_full[k]);
      check("model_req_ready", req_ready, mrdy);
      check("model_finish_instr", finish_instr, m_fin);
      check("model_instr_to_finish", instr_to_finish, m_ftag);
      check("model_finish_val", finish_val, m_fval);
      check("model_pending", pending, mcnt);
    end
    @(posedge clock);
    mg   = model_grant();
    mrdy = model_ready(mg);
    if (!reset) begin
      for (int k = 0; k < NR; k++) m_full[k] = 0;
      m_ptr = 0; m_fin = 0; m_ftag = '0; m_fval = '0; m_live = 1;
    end else if (m_live) begin
      if (flush) begin
        for (int k = 0; k < NR; k++) m_full[k] = 0;
        m_fin = 0; m_ftag = '0; m_fval = '0;
      end else begin
        if (mg >= 0) begin
          m_fin = 1; m_ftag = m_tag[mg]; m_fval = m_val[mg];
          m_full[mg] = 0;
          m_ptr = (mg + 1) % NR;
        end else begin
          m_fin = 0; m_ftag = '0; m_fval = '0;
        end
        for (int k = 0; k < NR; k++) begin
          if (req_valid[k] && mrdy[k]) begin
            m_full[k] = (req_tag[k*TW +: TW] != 0);
            m_tag[k]  = req_tag[k*TW +: TW];
            m_val[k]  = req_val[k*VW +: VW];
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    req_valid = '0;
    req_tag   = '0;
    req_val   = '0;
    hold      = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic present(input int k, input logic [31:0] t, input logic [31:0] v);
    req_valid[k]         = 1'b1;
    req_tag[k*TW +: TW]  = t;
    req_val[k*VW +: VW]  = v;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int unsigned ord_a [4];
    checks = 0;
    failures = 0;
    m_live = 0;
    reset = 1'b0;
    clear_in();

    // Reset and idle.
    tick(); tick();
    @(negedge clock);
    check("ready_in_reset", req_ready, 4'b0000);
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_reset", req_ready, 4'b1111);
    check("finish_after_reset", finish_instr, 0);
    check("pending_after_reset", pending, 0);
    check("tag_after_reset", instr_to_finish, 0);

    // Single unit 2: strobe two cycles later, pointer moves to 3.
    tick(); present(2, 32'h05, 32'hAB);
    tick(); clear_in();
    @(negedge clock);
    check("single_no_early_strobe", finish_instr, 0);
    check("single_pending", pending, 1);
    tick();
    @(negedge clock);
    check("single_strobe", finish_instr, 1);
    check("single_tag", instr_to_finish, 32'h05);
    check("single_val", finish_val, 32'hAB);
    check("single_model_pin_tag", m_ftag, 32'h05);

    // All four with ptr = 3: order units 3,0,1,2.
    ord_a = '{4, 1, 2, 3};
    tick(); for (int k = 0; k < NR; k++) present(k, 32'(k + 1), 32'(32'h100 + k));
    tick(); clear_in();
    @(negedge clock);
    check("ptr3_pending4", pending, 4);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clock);
      check("ptr3_strobe", finish_instr, 1);
      check("ptr3_order", instr_to_finish, ord_a[i]);
    end

    // Re-reset, all four with ptr = 0: order 1..4, pending 4..0.
    tick(); reset = 1'b0;
    tick(); reset = 1'b1;
    tick(); for (int k = 0; k < NR; k++) present(k, 32'(k + 1), 32'(32'h100 + k));
    tick(); clear_in();
    @(negedge clock);
    check("all4_pending4", pending, 4);
    check("all4_no_strobe_yet", finish_instr, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      @(negedge clock);
      check("all4_order", instr_to_finish, i);
      check("all4_val", finish_val, 32'h100 + i - 1);
      check("all4_pending", pending, 4 - i);
    end

    // Unit 0 streams eight tags with no bubbles.
    for (int i = 0; i < 11; i++) begin
      tick(); clear_in();
      if (i < 8) present(0, 32'(32'h10 + i), 32'(32'h1000 + i));
      @(negedge clock);
      if (i < 8) check("stream_ready0", req_ready[0], 1);
      if (i >= 2 && i < 10) begin
        check("stream_strobe", finish_instr, 1);
        check("stream_tag", instr_to_finish, 32'h10 + i - 2);
      end
      if (i == 10) check("stream_done", finish_instr, 0);
    end

    // Three slots loaded under hold, then one-cycle flush.
    tick(); hold = 1'b1;
    present(0, 32'h21, 32'h1); present(1, 32'h22, 32'h2); present(2, 32'h23, 32'h3);
    tick(); clear_in(); hold = 1'b1;
    @(negedge clock);
    check("flush_pre_pending", pending, 3);
    tick(); clear_in(); flush = 1'b1;
    @(negedge clock);
    check("flush_ready", req_ready, 4'b0000);
    check("flush_cycle_strobe", finish_instr, 0);
    tick(); clear_in();
    @(negedge clock);
    check("flush_pending", pending, 0);
    check("flush_after_strobe", finish_instr, 0);
    check("flush_after_ready", req_ready, 4'b1111);
    tick();
    @(negedge clock);
    check("flush_no_late_strobe", finish_instr, 0);

    // Zero tag on unit 1, hold three cycles, two slots full; ptr = 1.
    tick(); clear_in(); hold = 1'b1;
    present(1, 32'h0, 32'h99); present(0, 32'h30, 32'h300); present(3, 32'h33, 32'h333);
    tick(); clear_in(); hold = 1'b1;
    @(negedge clock);
    check("hold_ready", req_ready, 4'b0110);
    check("hold_pending", pending, 2);
    check("hold_strobe1", finish_instr, 0);
    tick(); clear_in(); hold = 1'b1;
    @(negedge clock);
    check("hold_strobe2", finish_instr, 0);
    tick(); clear_in();
    @(negedge clock);
    check("hold_strobe3", finish_instr, 0);
    check("hold_pending3", pending, 2);
    tick();
    @(negedge clock);
    check("resume_first", instr_to_finish, 32'h33);
    check("resume_first_val", finish_val, 32'h333);
    check("resume_pending1", pending, 1);
    tick();
    @(negedge clock);
    check("resume_second", instr_to_finish, 32'h30);
    check("resume_pending0", pending, 0);
    tick();
    @(negedge clock);
    check("resume_idle", finish_instr, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tick(); clear_in();
      req_valid = NR'($urandom);
      for (int k = 0; k < NR; k++) begin
        req_tag[k*TW +: TW] = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
        req_val[k*VW +: VW] = $urandom;
      end
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 99) != 0);
    end
    tick(); clear_in(); reset = 1'b1;
    repeat (6) tick();
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_finish_arbiter.md
# rob_finish_arbiter

Shares the reorder buffer's single completion port (`finish_instr`, `instr_to_finish`, `finish_val`) among `NUM_REQ` execution units. Each unit hands results over a valid/ready handshake into a private one-entry holding slot; a round-robin arbiter drains at most one slot per cycle into a registered finish pulse. The block sits between the functional units and the ROB, and also handles pipeline flush.

## Interface
- `NUM_REQ`, default 4: number of requesting execution units, legal range 2..8.
- `TAG_W`, default 32: instruction tag width, matches the ROB instruction field.
- `VAL_W`, default 32: result value width.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low. While it is 0, all state clears on the next edge and `req_ready` is forced to 0.
- `flush`  in  1: discard all held and in-flight results.
- `hold`  in  1: suppress new grants; slots keep their contents.
- `req_valid`  in  NUM_REQ: per-unit result valid.
- `req_tag`  in  NUM_REQ*TAG_W: flattened tags; unit k occupies bits [k*TAG_W +: TAG_W].
- `req_val`  in  NUM_REQ*VAL_W: flattened values, same packing as `req_tag`.
- `req_ready`  out  NUM_REQ: per-unit slot can accept a result this cycle.
- `finish_instr`  out  1: registered one-cycle completion strobe to the ROB.
- `instr_to_finish`  out  TAG_W: tag of the completing instruction.
- `finish_val`  out  VAL_W: result value of the completing instruction.
- `pending`  out  clog2(NUM_REQ+1): count of occupied slots.

## Operation
**Slot k**
- Holds one full bit, a tag and a value.
- A transfer happens when `req_valid[k] & req_ready[k]`.
- `req_ready[k] = reset & !flush & (!full[k] | grant[k])`, so the slot can be refilled in the same cycle it drains.
- A transfer with tag == 0 is accepted but not stored; the slot's full bit stays 0. Tag 0 means "no instruction" in the ROB.

**Grant**
- Eligible slots: `full & !hold & !flush`.
- Search order starts at pointer `ptr` and proceeds ptr, ptr+1, … modulo NUM_REQ. The first eligible slot is granted.
- On a grant to k: `ptr <= (k+1) mod NUM_REQ`. With no grant, `ptr` is unchanged.
- At most one grant per cycle.

**Output register**
- On a grant to k: `finish_instr <= 1`; `instr_to_finish` and `finish_val` load from slot k; `full[k]` clears unless refilled in the same cycle.
- With no grant: `finish_instr <= 0`, and `instr_to_finish`/`finish_val` are driven to 0.

**Flush**
- On the next edge: all full bits clear, `finish_instr` goes to 0, the output fields go to 0.
- `ptr` is not affected by flush.
- Flush takes priority over both accept and grant.

**`pending`**: population count of the full bits (registered state, not next-state).

## Timing
- Reset values: `finish_instr` 0, `instr_to_finish` 0, `finish_val` 0, `pending` 0, `ptr` 0, all slots empty. `req_ready` is 0 while `reset` = 0, and all 1 on the first cycle after release.
- Latency: a transfer at cycle t gives, at the earliest, `finish_instr` high during cycle t+2.
- Back-to-back:
  - One unit streaming every cycle produces one strobe per cycle with no bubbles, because same-cycle drain and refill is allowed.
  - N contending units each get one grant per N cycles; worst-case wait is NUM_REQ-1 grants.
- `hold`:
  - Grants are blocked on the cycle `hold` is high.
  - An already-registered strobe still appears.
  - `req_ready` for empty slots stays 1.
- The ROB has no backpressure; every strobe is consumed in its cycle.
- Simultaneous `flush` and `reset` = 0: reset result (identical state).

## Structure
- Shared package `ooo_pkg`: `TAG_W`/`VAL_W` defaults, `NULL_TAG` = 0, and the `clog2` helper for `pending`.
- One sub-module: `rr_pick`, a combinational round-robin priority picker.
  - Inputs: eligible vector and `ptr`.
  - Outputs: one-hot grant and grant index.
  - Reusable later for the ROB dispatch-side arbiter.
- Slots, pointer and output register live in the top level.

## Test plan
- Reset, then idle: `req_ready` = 4'b1111, `finish_instr` 0, `pending` 0; reset held low forces `req_ready` = 0.
- Single unit 2 presents tag 0x05, val 0xAB at cycle t: strobe at t+2 with tag 0x05, val 0xAB; `ptr` becomes 3.
- All four units load at once (tags 1–4) with `ptr` = 0: strobes on four consecutive cycles in order 1, 2, 3, 4; `pending` goes 4, 3, 2, 1, 0.
- Unit 0 streams tags 0x10–0x17 every cycle, others idle: eight consecutive strobes with no gaps; `req_ready[0]` stays 1.
- Three slots full, assert `flush` for one cycle: next cycle `pending` 0, no strobes follow, `req_ready` is 0 during the flush cycle and all 1 after.
- Zero-tag transfer on unit 1, `hold` high for 3 cycles with two slots full: no strobe for tag 0; no grants during `hold`; grants resume in round-robin order on release.
